// File: rtl/load_store_ctrl.sv
// load_store_ctrl: multicycle sequencer for the memory load/store path.
// Accepts one request at a time, drives the memory address and write strobe,
// waits out the memory read latency, and pulses the MDR load. It also holds
// load_size_control for the downstream LW/LH/LB size-extract unit. SH and SB
// run as read-modify-write on the 32-bit word, in the low lane only.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   - misaligned LW/SW/LH/SH finish at once with misalign=1 with done
//   undefined - no check; misalign stays 0; misaligned address used as-is
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   start, op          request strobe (IDLE only) and opcode
//                      000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB
//   addr, store_data   byte address and store operand, latched on accept
//   mem_rdata          memory read data, valid MEM_LAT cycles after mem_addr
//   mem_addr, mem_wdata  registered memory address / write data
//   mem_wr, mdr_wr     one-cycle write strobes (never both high)
//   load_size_control  00 LW, 01 LH, 10 LB
//   busy, done         busy outside IDLE; one-cycle completion pulse
//   misalign           alignment fault flag, high together with done
module load_store_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        mdr_wr,
  output logic [1:0]  load_size_control,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  lsc_q, lsc_d;
  logic        misalign_q, misalign_d;

  logic        op_valid;
  logic        align_fault;
  logic [31:0] keep_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      sdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lsc_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sdata_q     <= sdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lsc_q       <= lsc_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sdata_d     = sdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lsc_d       = lsc_q;
    misalign_d  = 1'b0;
    mem_wr      = 1'b0;
    mdr_wr      = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);

    op_valid = (op[1:0] != 2'b11);
`ifdef ALIGN_CHECK_EN
    align_fault = ((op[1:0] == 2'b00) && (addr[1:0] != 2'b00)) ||
                  ((op[1:0] == 2'b01) && addr[0]);
`else
    align_fault = 1'b0;
`endif
    // Bits of the read word that survive the merge: SH keeps [31:16], SB [31:8].
    keep_mask = (op_q[1:0] == 2'b01) ? 32'hFFFF_0000 : 32'hFFFF_FF00;

    unique case (state_q)
      S_IDLE: begin
        if (start && op_valid) begin
          op_d    = op;
          sdata_d = store_data;
          cnt_d   = CW'(MEM_LAT - 1);
          if (!op[2]) lsc_d = op[1:0];
          if (align_fault) begin
            // Faulting request skips memory entirely; mem_addr keeps its old value.
            misalign_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            mem_addr_d = addr;
            if (op == 3'b100) begin
              mem_wdata_d = store_data;
              state_d     = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) state_d = op_q[2] ? S_MERGE : S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        mdr_wr  = 1'b1;
        state_d = S_DONE;
      end
      S_MERGE: begin
        mem_wdata_d = (mem_rdata & keep_mask) | (sdata_q & ~keep_mask);
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        mem_wr  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign load_size_control = lsc_q;
  assign misalign          = misalign_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
module tb_load_store_ctrl;

  localparam int unsigned L = 2;
  localparam int K_MDR  = 1;
  localparam int K_WR   = 2;
  localparam int K_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mdr_wr;
  logic [1:0]  load_size_control;
  logic        busy;
  logic        done;
  logic        misalign;

  load_store_ctrl #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mdr_wr(mdr_wr),
    .load_size_control(load_size_control), .busy(busy), .done(done),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  lsc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv)
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    else
      passed++;
  endtask

  // Monitor: pops one expectation per observed strobe.
  exp_t e;
  int   k;
  always @(negedge clk) begin
    if (mdr_wr || mem_wr || done) begin
      chk("wr_exclusive", {31'd0, mdr_wr & mem_wr}, 32'd0);
      k = mdr_wr ? K_MDR : (mem_wr ? K_WR : K_DONE);
      if (q.size() == 0) begin
        chk("unexpected_event", k, 0);
      end else begin
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (k == K_MDR) begin
          chk("mdr_addr", mem_addr, e.a);
          chk("mdr_lsc", {30'd0, load_size_control}, {30'd0, e.lsc});
        end else if (k == K_WR) begin
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end else begin
          chk("done_misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("done_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  function automatic exp_t mk(int kind, int c, logic [31:0] a, logic [31:0] d,
                              logic [1:0] lsc, logic mis);
    exp_t r;
    r.kind = kind; r.cyc = c; r.a = a; r.d = d; r.lsc = lsc; r.mis = mis;
    return r;
  endfunction

  // Issue one request; expectations are hand-supplied (wd = expected write data,
  // fault = expected alignment fault). start stays high for 1+hold cycles.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input logic [31:0] wd, input bit fault,
                       input bit track, input int hold);
    int t0;
    @(negedge clk);
    op = o; addr = a; store_data = sd; mem_rdata = rd; start = 1'b1;
    t0 = cyc;
    if (track) begin
      if (fault) begin
        q.push_back(mk(K_DONE, t0 + 1, '0, '0, '0, 1'b1));
      end else if (!o[2]) begin
        q.push_back(mk(K_MDR, t0 + L + 1, a, '0, o[1:0], 1'b0));
        q.push_back(mk(K_DONE, t0 + L + 2, '0, '0, '0, 1'b0));
      end else if (o == 3'b100) begin
        q.push_back(mk(K_WR, t0 + 1, a, wd, '0, 1'b0));
        q.push_back(mk(K_DONE, t0 + 2, '0, '0, '0, 1'b0));
      end else begin
        q.push_back(mk(K_WR, t0 + L + 2, a, wd, '0, 1'b0));
        q.push_back(mk(K_DONE, t0 + L + 3, '0, '0, '0, 1'b0));
      end
    end
    repeat (1 + hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_lsc", {30'd0, load_size_control}, 32'd0);
    chk("rst_strobes", {29'd0, mem_wr, mdr_wr, done}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: LW
    issue(3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);

    // 2: LB then LH back-to-back
    issue(3'b010, 32'h13, 32'h0, 32'h01020304, 32'h0, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    issue(3'b001, 32'h16, 32'h0, 32'h05060708, 32'h0, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);

    // 3: SH and SB read-modify-write
    issue(3'b101, 32'h20, 32'h0000ABCD, 32'h11223344, 32'h1122ABCD, 1'b0, 1'b1, 0);
    repeat (6) @(negedge clk);
    issue(3'b110, 32'h20, 32'h0000ABCD, 32'h11223344, 32'h112233CD, 1'b0, 1'b1, 0);
    repeat (6) @(negedge clk);
    chk("sb_lsc_held", {30'd0, load_size_control}, 32'd1);

    // 4: SW with start held through WRITE and DONE
    issue(3'b100, 32'h30, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 2);
    repeat (6) @(negedge clk);
    chk("sw_wdata_held", mem_wdata, 32'hCAFEF00D);
    chk("sw_addr_held", mem_addr, 32'h30);

    // 5: reset during READ, then a reserved opcode
    issue(3'b000, 32'h40, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_lsc", {30'd0, load_size_control}, 32'd0);
    repeat (4) @(negedge clk);
    issue(3'b011, 32'h50, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    chk("reserved_busy", {31'd0, busy}, 32'd0);
    chk("reserved_mem_addr", mem_addr, 32'd0);
    repeat (3) @(negedge clk);

    // 6: misaligned LW
`ifdef ALIGN_CHECK_EN
    issue(3'b000, 32'h22, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clk);
    chk("fault_mem_addr_kept", mem_addr, 32'd0);
`else
    issue(3'b000, 32'h22, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);
`endif

    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
